// File: rtl/dp_pkg.sv
// Shared encodings for the data-processing instruction sequencer: shift types,
// ALU opcodes, condition codes, FSM states and the instruction field layout.
package dp_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned NZCV_W  = 4;
  localparam int unsigned SHNUM_W = 8;
  localparam int unsigned SHOP_W  = 3;
  localparam int unsigned ALUOP_W = 4;

  typedef enum logic [SHOP_W-1:0] {
    LSL_IMM = 3'b000,
    LSL_REG = 3'b001,
    LSR_IMM = 3'b010,
    LSR_REG = 3'b011,
    ASR_IMM = 3'b100,
    ASR_REG = 3'b101,
    ROR_IMM = 3'b110,
    ROR_REG = 3'b111
  } shift_op_e;

  typedef enum logic [ALUOP_W-1:0] {
    OP_AND = 4'b0000,
    OP_EOR = 4'b0001,
    OP_SUB = 4'b0010,
    OP_RSB = 4'b0011,
    OP_ADD = 4'b0100,
    OP_ADC = 4'b0101,
    OP_SBC = 4'b0110,
    OP_RSC = 4'b0111,
    OP_TST = 4'b1000,
    OP_TEQ = 4'b1001,
    OP_CMP = 4'b1010,
    OP_CMN = 4'b1011,
    OP_ORR = 4'b1100,
    OP_MOV = 4'b1101,
    OP_BIC = 4'b1110,
    OP_MVN = 4'b1111
  } alu_op_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_READ1  = 3'd2,
    S_READ2  = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5
  } state_e;

  // Data-processing instruction word, MSB first.
  typedef struct packed {
    logic [3:0]  cond;
    logic [1:0]  cls;
    logic        imm;
    logic [3:0]  opcode;
    logic        s;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] op2;
  } dp_instr_t;

  // TST/TEQ/CMP/CMN only update flags; they never write a register.
  function automatic logic is_test_op(input logic [ALUOP_W-1:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/dp_cond_check.sv
// Combinational ARM condition-code evaluator against the current {N,Z,C,V}.
module dp_cond_check
  import dp_pkg::*;
(
  input  logic [3:0]        cond,
  input  logic [NZCV_W-1:0] nzcv,
  output logic              pass_c
);

  logic n, z, c, v;

  assign {n, z, c, v} = nzcv;

  always_comb begin
    pass_c = 1'b0;
    case (cond)
      COND_EQ: pass_c = z;
      COND_NE: pass_c = !z;
      COND_CS: pass_c = c;
      COND_CC: pass_c = !c;
      COND_MI: pass_c = n;
      COND_PL: pass_c = !n;
      COND_VS: pass_c = v;
      COND_VC: pass_c = !v;
      COND_HI: pass_c = c && !z;
      COND_LS: pass_c = !c || z;
      COND_GE: pass_c = (n == v);
      COND_LT: pass_c = (n != v);
      COND_GT: pass_c = !z && (n == v);
      COND_LE: pass_c = z || (n != v);
      COND_AL: pass_c = 1'b1;
      default: pass_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/dp_instr_sequencer.sv
// Multi-cycle controller that steps one data-processing instruction through
// decode, register read, a single execute cycle and register write-back.
module dp_instr_sequencer
  import dp_pkg::*;
#(
  parameter int unsigned REG_AW = 4,
  parameter int unsigned DW     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr,
  input  logic [NZCV_W-1:0]  nzcv_in,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [REG_AW-1:0]  rf_ra0,
  output logic [REG_AW-1:0]  rf_ra1,
  input  logic [DW-1:0]      rf_rd0,
  input  logic [DW-1:0]      rf_rd1,
  output logic               alu_s,
  output logic [DW-1:0]      alu_a,
  output logic [DW-1:0]      shift_data,
  output logic [SHNUM_W-1:0] shift_num,
  output logic [SHOP_W-1:0]  shift_op,
  output logic [ALUOP_W-1:0] alu_op,
  input  logic [DW-1:0]      alu_f,
  output logic               wr_en,
  output logic [REG_AW-1:0]  wr_addr,
  output logic [DW-1:0]      wr_data
);

  state_e    state_q, state_d;
  dp_instr_t instr_q;
  logic [DW-1:0] rn_q, rm_q;
  logic [DW-1:0] rn_c, rm_c;
  logic cond_pass;
  logic is_dp;
  logic reg_shift;
  logic test_op;

  assign is_dp     = (instr_q.cls == 2'b00);
  assign reg_shift = !instr_q.imm && instr_q.op2[4];
  assign test_op   = is_test_op(instr_q.opcode);

  // Operands straight from the register file when leaving READ1, else the latched copy.
  assign rn_c = (state_q == S_READ1) ? rf_rd0 : rn_q;
  assign rm_c = (state_q == S_READ1) ? rf_rd1 : rm_q;

  dp_cond_check u_cond (
    .cond   (instr_q.cond),
    .nzcv   (nzcv_in),
    .pass_c (cond_pass)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_DECODE;
      S_DECODE: state_d = (!is_dp || !cond_pass) ? S_WB : S_READ1;
      S_READ1:  state_d = reg_shift ? S_READ2 : S_EXEC;
      S_READ2:  state_d = S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Instruction and read-operand capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
    end else begin
      if (state_q == S_IDLE && start) instr_q <= dp_instr_t'(instr);
      if (state_q == S_READ1) begin
        rn_q <= rf_rd0;
        rm_q <= rf_rd1;
      end
    end
  end

  // Handshake, strobes and register-file read addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      alu_s  <= 1'b0;
      wr_en  <= 1'b0;
      rf_ra0 <= '0;
      rf_ra1 <= '0;
    end else begin
      busy  <= (state_d != S_IDLE);
      done  <= (state_d == S_WB);
      err   <= (state_q == S_DECODE) && !is_dp;
      alu_s <= (state_d == S_EXEC) && (instr_q.s || test_op);
      wr_en <= (state_q == S_EXEC) && !test_op;
      case (state_d)
        S_READ1: begin
          rf_ra0 <= REG_AW'(instr_q.rn);
          rf_ra1 <= REG_AW'(instr_q.op2[3:0]);
        end
        S_READ2: begin
          rf_ra0 <= REG_AW'(instr_q.op2[11:8]);
          rf_ra1 <= '0;
        end
        default: begin
          rf_ra0 <= '0;
          rf_ra1 <= '0;
        end
      endcase
    end
  end

  // Datapath controls load on entry to EXEC and hold through WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op     <= '0;
      alu_a      <= '0;
      shift_data <= '0;
      shift_num  <= '0;
      shift_op   <= '0;
    end else if (state_d == S_EXEC) begin
      alu_op <= instr_q.opcode;
      alu_a  <= rn_c;
      if (instr_q.imm) begin
        shift_data <= DW'(instr_q.op2[7:0]);
        shift_num  <= {3'b000, instr_q.op2[11:8], 1'b0};
        shift_op   <= ROR_IMM;
      end else begin
        shift_data <= rm_c;
        shift_op   <= {instr_q.op2[6:5], instr_q.op2[4]};
        shift_num  <= instr_q.op2[4] ? SHNUM_W'(rf_rd0) : {3'b000, instr_q.op2[11:7]};
      end
    end else if (state_d == S_IDLE) begin
      alu_op     <= '0;
      alu_a      <= '0;
      shift_data <= '0;
      shift_num  <= '0;
      shift_op   <= '0;
    end
  end

  // Result capture at the end of EXEC doubles as the write-back payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr <= '0;
      wr_data <= '0;
    end else if (state_q == S_EXEC) begin
      wr_addr <= REG_AW'(instr_q.rd);
      wr_data <= alu_f;
    end else if (state_d == S_IDLE) begin
      wr_addr <= '0;
      wr_data <= '0;
    end
  end

endmodule

// File: tb/tb_dp_instr_sequencer.sv
// Self-checking bench: directed vector table, hand-written reset/busy sequences
// and randomized instructions scored against a behavioural model.
module tb_dp_instr_sequencer;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  nzcv;
    int          hold;
    int          lat;
    logic        err;
    int          n_alus;
    int          n_wr;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] alu_a;
    logic [31:0] sdata;
    logic [7:0]  snum;
    logic [2:0]  sop;
    logic [3:0]  aop;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] instr;
  logic [3:0]  nzcv_in;
  logic        busy, done, err;
  logic [3:0]  rf_ra0, rf_ra1;
  logic [31:0] rf_rd0, rf_rd1;
  logic        alu_s;
  logic [31:0] alu_a, shift_data;
  logic [7:0]  shift_num;
  logic [2:0]  shift_op;
  logic [3:0]  alu_op;
  logic [31:0] alu_f;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;

  logic [31:0] regs [16];
  int n_tests = 0;
  int n_fail  = 0;
  string cur_tag = "";
  vec_t tbl [9];

  always #5 clk = !clk;

  dp_instr_sequencer #(.REG_AW(4), .DW(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .instr      (instr),
    .nzcv_in    (nzcv_in),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .rf_ra0     (rf_ra0),
    .rf_ra1     (rf_ra1),
    .rf_rd0     (rf_rd0),
    .rf_rd1     (rf_rd1),
    .alu_s      (alu_s),
    .alu_a      (alu_a),
    .shift_data (shift_data),
    .shift_num  (shift_num),
    .shift_op   (shift_op),
    .alu_op     (alu_op),
    .alu_f      (alu_f),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  // Plain barrel shifter + ALU standing in for the real datapath.
  function automatic logic [31:0] dp_eval(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] d, input logic [7:0] amt,
                                          input logic [2:0] sop);
    logic [31:0] b;
    logic [31:0] r;
    int n;
    int rr;
    n  = int'(amt);
    rr = n % 32;
    case (sop[2:1])
      2'b00:   b = (n >= 32) ? '0 : (d << n);
      2'b01:   b = (n >= 32) ? '0 : (d >> n);
      2'b10:   b = (n >= 32) ? {32{d[31]}} : 32'($signed(d) >>> n);
      default: b = (rr == 0) ? d : ((d >> rr) | (d << (32 - rr)));
    endcase
    case (op)
      4'h0, 4'h8:       r = a & b;
      4'h1, 4'h9:       r = a ^ b;
      4'h2, 4'h6, 4'hA: r = a - b;
      4'h3, 4'h7:       r = b - a;
      4'h4, 4'h5, 4'hB: r = a + b;
      4'hC:             r = a | b;
      4'hD:             r = b;
      4'hE:             r = a & ~b;
      default:          r = ~b;
    endcase
    return r;
  endfunction

  // Conditions come in complementary pairs: the odd code negates the even one.
  function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
    logic base;
    if (cond == 4'hF) return 1'b0;
    case (cond[3:1])
      3'd0: base = f[2];
      3'd1: base = f[1];
      3'd2: base = f[3];
      3'd3: base = f[0];
      3'd4: base = f[1] && !f[2];
      3'd5: base = (f[3] == f[0]);
      3'd6: base = !f[2] && (f[3] == f[0]);
      default: base = 1'b1;
    endcase
    return cond[0] ? !base : base;
  endfunction

  function automatic vec_t model(input logic [31:0] ins, input logic [3:0] f, input int hold);
    vec_t e;
    logic [3:0] op;
    logic cmp;
    logic [31:0] rs;
    e = '{default: 0};
    e.instr = ins;
    e.nzcv  = f;
    e.hold  = hold;
    e.lat   = 2;
    if (ins[27:26] != 2'b00) begin
      e.err = 1'b1;
      return e;
    end
    if (!cond_ok(ins[31:28], f)) return e;
    op     = ins[24:21];
    e.aop  = op;
    e.alu_a = regs[ins[19:16]];
    if (ins[25]) begin
      e.sdata = {24'b0, ins[7:0]};
      e.snum  = 8'(2 * int'(ins[11:8]));
      e.sop   = 3'b110;
      e.lat   = 4;
    end else begin
      e.sdata = regs[ins[3:0]];
      e.sop   = ins[6:4];
      if (ins[4]) begin
        rs     = regs[ins[11:8]];
        e.snum = rs[7:0];
        e.lat  = 5;
      end else begin
        e.snum = 8'(ins[11:7]);
        e.lat  = 4;
      end
    end
    cmp       = (op >= 4'd8) && (op <= 4'd11);
    e.n_alus  = (ins[20] || cmp) ? 1 : 0;
    e.n_wr    = cmp ? 0 : 1;
    e.wr_addr = ins[15:12];
    e.wr_data = dp_eval(op, e.alu_a, e.sdata, e.snum, e.sop);
    return e;
  endfunction

  assign rf_rd0 = regs[rf_ra0];
  assign rf_rd1 = regs[rf_ra1];
  always_comb alu_f = dp_eval(alu_op, alu_a, shift_data, shift_num, shift_op);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got 0x%0h expected 0x%0h", cur_tag, name, act, exp);
    end
  endtask

  // Issue one instruction, watch 14 cycles, compare everything against v.
  task automatic apply(input vec_t v, input string tag);
    int lat = 0, n_done = 0, n_alus = 0, n_wr = 0, alus_at = -1;
    int busy_bad = 0, idle_bad = 0;
    logic err_s = 1'b0, wr_s = 1'b0;
    logic [31:0] a_s = '0, d_s = '0, wd_s = '0;
    logic [7:0]  sn_s = '0;
    logic [2:0]  so_s = '0;
    logic [3:0]  op_s = '0, wa_s = '0;
    cur_tag = tag;
    @(negedge clk);
    instr   = v.instr;
    nzcv_in = v.nzcv;
    start   = 1'b1;
    for (int n = 0; n < 14; n++) begin
      @(posedge clk);
      #1;
      if (n >= v.hold) start = 1'b0;
      if (alu_s) begin n_alus++; alus_at = n; end
      if (wr_en) n_wr++;
      if (n_done == 0 && !busy) busy_bad++;
      if (n_done > 0 && (busy || done || err || alu_s || wr_en || alu_a != '0 ||
                         shift_data != '0 || shift_num != '0 || alu_op != '0 ||
                         wr_data != '0 || rf_ra0 != '0)) idle_bad++;
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          lat = n + 1;
          err_s = err; wr_s = wr_en; wa_s = wr_addr; wd_s = wr_data;
          a_s = alu_a; d_s = shift_data; sn_s = shift_num; so_s = shift_op; op_s = alu_op;
        end
      end
    end
    chk("latency", 32'(lat), 32'(v.lat));
    chk("done_count", 32'(n_done), 32'd1);
    chk("err", 32'(err_s), 32'(v.err));
    chk("alu_s_cycles", 32'(n_alus), 32'(v.n_alus));
    if (v.n_alus > 0) chk("alu_s_in_exec", 32'(alus_at), 32'(v.lat - 2));
    chk("wr_en_cycles", 32'(n_wr), 32'(v.n_wr));
    chk("busy_window", 32'(busy_bad), 32'd0);
    chk("idle_zero", 32'(idle_bad), 32'd0);
    chk("alu_a", a_s, v.alu_a);
    chk("shift_data", d_s, v.sdata);
    chk("shift_num", 32'(sn_s), 32'(v.snum));
    chk("shift_op", 32'(so_s), 32'(v.sop));
    chk("alu_op", 32'(op_s), 32'(v.aop));
    if (v.n_wr > 0) begin
      chk("wr_en_at_done", 32'(wr_s), 32'd1);
      chk("wr_addr", 32'(wa_s), 32'(v.wr_addr));
      chk("wr_data", wd_s, v.wr_data);
    end
  endtask

  initial begin
    int quiet_bad;
    rst_n = 1'b0; start = 1'b0; instr = '0; nzcv_in = '0;
    for (int i = 0; i < 16; i++) regs[i] = 32'hDEAD_0000 + 32'(i);
    regs[0] = 32'h1111_1111; regs[2] = 32'h10;  regs[3] = 32'h3;  regs[4] = 32'h105;
    regs[5] = 32'h55;        regs[7] = 32'h100; regs[8] = 32'hF0;

    //        instr          nzcv hold lat err alus wr  wa    wd             alu_a          sdata     snum sop     aop
    tbl[0] = '{32'hE3A034FF, 4'h0, 0, 4, 1'b0, 0, 1, 4'd3, 32'hFF00_0000, 32'h1111_1111, 32'hFF,  8'd8, 3'b110, 4'hD};
    tbl[1] = '{32'hE0821413, 4'h0, 0, 5, 1'b0, 0, 1, 4'd1, 32'h70,        32'h10,        32'h3,   8'd5, 3'b001, 4'h4};
    tbl[2] = '{32'hE3550001, 4'h0, 0, 4, 1'b0, 1, 0, 4'd0, 32'h0,         32'h55,        32'h1,   8'd0, 3'b110, 4'hA};
    tbl[3] = '{32'h03A01001, 4'h0, 0, 2, 1'b0, 0, 0, 4'd0, 32'h0,         32'h0,         32'h0,   8'd0, 3'b000, 4'h0};
    tbl[4] = '{32'h03A01001, 4'h4, 0, 4, 1'b0, 0, 1, 4'd1, 32'h1,         32'h1111_1111, 32'h1,   8'd0, 3'b110, 4'hD};
    tbl[5] = '{32'hE5912000, 4'h0, 2, 2, 1'b1, 0, 0, 4'd0, 32'h0,         32'h0,         32'h0,   8'd0, 3'b000, 4'h0};
    tbl[6] = '{32'hF3A01001, 4'hF, 0, 2, 1'b0, 0, 0, 4'd0, 32'h0,         32'h0,         32'h0,   8'd0, 3'b000, 4'h0};
    tbl[7] = '{32'hE0976228, 4'h0, 0, 4, 1'b0, 1, 1, 4'd6, 32'h10F,       32'h100,       32'hF0,  8'd4, 3'b010, 4'h4};
    tbl[8] = '{32'hE3A034FF, 4'h0, 4, 4, 1'b0, 0, 1, 4'd3, 32'hFF00_0000, 32'h1111_1111, 32'hFF,  8'd8, 3'b110, 4'hD};

    // Reset state
    cur_tag = "reset";
    repeat (3) @(posedge clk);
    #1;
    chk("ctrl", 32'({busy, done, err, alu_s, wr_en}), 32'd0);
    chk("ra", 32'({rf_ra0, rf_ra1, wr_addr}), 32'd0);
    chk("ops", alu_a | shift_data | wr_data, 32'd0);
    chk("fields", 32'({shift_num, shift_op, alu_op}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset dropped while executing: immediate clear, no done/write afterwards.
    cur_tag = "rst_in_exec";
    @(negedge clk);
    instr = 32'hE3A034FF; nzcv_in = 4'h0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("exec_alu_op", 32'(alu_op), 32'hD);
    rst_n = 1'b0;
    #1;
    chk("ctrl", 32'({busy, done, err, alu_s, wr_en}), 32'd0);
    chk("ops", alu_a | shift_data | wr_data, 32'd0);
    chk("fields", 32'({shift_num, shift_op, alu_op, rf_ra0}), 32'd0);
    quiet_bad = 0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      if (done || wr_en || busy) quiet_bad++;
    end
    chk("quiet", 32'(quiet_bad), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(tbl[0], "post_rst");

    // Randomized instructions against the model.
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    for (int i = 0; i < 200; i++) begin
      logic [31:0] ins;
      ins = $urandom;
      if ($urandom_range(9) != 0) ins[27:26] = 2'b00;
      if ($urandom_range(1) != 0) ins[31:28] = 4'hE;
      apply(model(ins, 4'($urandom), int'($urandom_range(2))), $sformatf("rnd%0d_%08h", i, ins));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dp_instr_sequencer.md
Name: dp_instr_sequencer

Overview:
- Multi-cycle controller that drives the shifter+ALU datapath from an ARM-style data-processing instruction word.
- Per instruction: checks the condition field, reads register operands, drives shift and ALU controls for exactly one execute cycle, captures the result, and issues the register-file write-back.
- Sits between instruction fetch and the register file / ALU_barrel datapath; it is the initiator of the control interface the datapath obeys.

Parameters:
- REG_AW, 4, register-file address width (16 registers).
- DW, 32, datapath width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  instruction valid; sampled only when busy=0.
- instr  in  32  instruction word; latched on an accepted start.
- nzcv_in  in  4  current flag register {N,Z,C,V}.
- busy  out  1  high from the accept edge until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  high with done when the instruction is not data-processing.
- rf_ra0  out  REG_AW  read address port 0 (Rn, then Rs).
- rf_ra1  out  REG_AW  read address port 1 (Rm).
- rf_rd0  in  DW  read data 0 (combinational from rf_ra0).
- rf_rd1  in  DW  read data 1 (combinational from rf_ra1).
- alu_s  out  1  flag-update enable to the datapath.
- alu_a  out  DW  ALU operand A.
- shift_data  out  DW  shifter input.
- shift_num  out  8  shift amount.
- shift_op  out  3  shift type.
- alu_op  out  4  ALU opcode.
- alu_f  in  DW  datapath result.
- wr_en  out  1  register write strobe.
- wr_addr  out  REG_AW  destination register.
- wr_data  out  DW  write data.

Behaviour:
- Reset: all outputs 0; state IDLE.
- Reset asserted mid-instruction aborts immediately: no write, no done.
- States and transitions:
  - IDLE: on start, latch instr and go to DECODE.
  - DECODE:
    - instr[27:26]!=00 -> WB with err=1.
    - Condition fails -> WB with no write.
    - Otherwise -> READ1.
  - READ1: rf_ra0=Rn[19:16], rf_ra1=Rm[3:0]; latch both read data at cycle end.
    - -> READ2 if I=0 and bit4=1 (register-specified shift).
    - Otherwise -> EXEC.
  - READ2: rf_ra0=Rs[11:8]; latch rf_rd0[7:0] as the shift amount; -> EXEC.
  - EXEC: capture alu_f into the result register; -> WB.
  - WB: done=1 for one cycle; wr_en=1 if writing; -> IDLE.
- Condition evaluation: standard ARM codes 0000..1110 evaluated on nzcv_in sampled in DECODE. cond=1111 always fails.
- Operand mapping:
  - alu_op = instr[24:21]; alu_a = latched Rn.
  - I=1: shift_data = {24'b0, imm8}; shift_num = {3'b0, rot, 1'b0}; shift_op = ROR_IMM.
  - I=0: shift_data = Rm; shift_op = {instr[6:5], instr[4]}; shift_num = {3'b0, instr[11:7]} if bit4=0, else Rs[7:0].
- Control-output timing:
  - Operand and control outputs are registered and stable from entry into EXEC through WB; 0 in IDLE.
  - alu_s is high only during the EXEC cycle, so the datapath updates flags exactly once.
  - alu_s = instr[20], forced to 1 for opcodes 1000..1011 (TST/TEQ/CMP/CMN).
- Write-back:
  - wr_en is suppressed for opcodes 1000..1011, on condition fail, and on err.
  - wr_addr = Rd[15:12]; wr_data = captured result.
- Latency (start sampled at edge k; done sampled high at edge):
  - k+4: immediate or immediate-shift operand.
  - k+5: register-specified shift.
  - k+2: condition fail or err.
- start while busy is ignored. A back-to-back start sampled in the WB cycle is not accepted; acceptance resumes in IDLE.

Decomposition:
- Package dp_pkg holds:
  - shift_op encodings: LSL_IMM 000, LSL_REG 001, LSR_IMM 010, LSR_REG 011, ASR_IMM 100, ASR_REG 101, ROR_IMM 110, ROR_REG 111.
  - ALU opcode constants: AND 0000 … MVN 1111.
  - Condition codes.
  - The FSM state enum.
- One sub-module, dp_cond_check: combinational cond + nzcv -> pass.

Test Plan:
- MOV R3,#0xFF000000 (0xE3A034FF); bench ALU returns 0xFF000000.
  -> shift_data=0xFF, shift_num=8, shift_op=110, alu_op=1101, alu_s high 1 cycle.
  -> wr_en with wr_addr=3, wr_data=0xFF000000; done at k+4.
- ADD R1,R2,R3,LSL R4 (0xE0821413) with R4=0x105.
  -> READ2 visited; shift_num=0x05, shift_op=001, alu_a=R2; done at k+5; wr_addr=1.
- CMP R5,#1 (0xE3550001).
  -> alu_s=1 in EXEC, wr_en never asserted, done at k+4.
- MOVEQ R1,#1 (0x03A01001) with nzcv_in=0000.
  -> done at k+2, alu_s and wr_en stay 0.
  -> Repeat with nzcv_in=0100: full execution, wr_addr=1.
- LDR word 0xE5912000.
  -> err=1 with done at k+2, no write; start pulses while busy are ignored.
- rst_n dropped in EXEC.
  -> all outputs 0 asynchronously, no wr_en; the next start after release executes normally.
